// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and helpers for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam int WORD_W           = 32;
  localparam int ADDR_W           = 30;
  localparam int CNT_W            = 4;
  localparam int DEFAULT_END_ADDR = 255;

  // Storage keeps bus order; monitors call this to print words most-significant byte first.
  function automatic logic [WORD_W-1:0] le_to_readable(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/dmem_latency_ctr.sv
// rtl/dmem_latency_ctr.sv - loadable down-counter timing the WAIT phase of an access
module dmem_latency_ctr
  import dmem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Expiry at 1 so the FSM lands in RESP exactly LATENCY-1 edges after acceptance.
  assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency word memory on the core data port
// Optional end-of-program detector enabled by defining DMEM_DONE_DETECT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 4,
  parameter int END_ADDR = DEFAULT_END_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              prot_err,
  output logic              done
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(LATENCY - 1);

  dmem_state_e       r_state;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_prot_err;

  logic              w_req;
  logic              w_req_in_range;
  logic              w_lat_in_range;
  logic              w_expire;
  logic              w_load;
  logic              w_dec;
  logic [WORD_W-1:0] w_req_rdata;
  logic [WORD_W-1:0] w_lat_rdata;

  assign w_req          = mem_read | mem_write;
  assign w_req_in_range = (mem_addr < DEPTH_A);
  assign w_lat_in_range = (r_addr < DEPTH_A);
  assign w_load         = (r_state == IDLE) && w_req;
  assign w_dec          = (r_state == WAIT);

  // Writes and out-of-range reads answer with zero.
  assign w_req_rdata = (mem_write || !w_req_in_range) ? '0 : r_mem[mem_addr[IDX_W-1:0]];
  assign w_lat_rdata = (r_is_write || !w_lat_in_range) ? '0 : r_mem[r_addr[IDX_W-1:0]];

  dmem_latency_ctr #(
    .W (CNT_W)
  ) u_latency_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_expire   (w_expire)
  );

`ifdef DMEM_DONE_DETECT_EN
  localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);
  logic r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else if ((r_state == RESP) && r_is_write && w_lat_in_range && (r_addr == END_A)) begin
      r_done <= 1'b1;
    end
  end

  assign done = r_done;
`else
  assign done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_prot_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // Simultaneous read and write resolves to a write.
            r_is_write <= mem_write;
            r_addr     <= mem_addr;
            r_wdata    <= mem_wdata;
            if ((mem_read && mem_write) || !w_req_in_range) begin
              r_prot_err <= 1'b1;
            end
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_rdata <= w_req_rdata;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (w_expire) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_rdata <= w_lat_rdata;
          end
        end
        RESP: begin
          if (r_is_write && w_lat_in_range) begin
            r_mem[r_addr[IDX_W-1:0]] <= r_wdata;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign mem_stall = (r_state != RESP) & w_req;
  assign prot_err  = r_prot_err;

endmodule
